seg_scan_ctrl: RTL

- Memory-mapped scan controller for the board's 4-digit multiplexed seven-segment display.
- The CPU writes a 16-bit hex value and a control word over the peripheral bus.
- The block time-multiplexes the digits itself, with refresh dwell, inter-digit ghost gap, hex decode, per-digit blank/decimal-point masks and tear-free frame updates.
- Replaces software-driven direct writes of sel/seg bits.

---
 rtl/seg_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Memory-mapped scan controller for a 4-digit multiplexed
//               seven-segment display.
//
//               The CPU writes a 16-bit hex VALUE and a CTRL word. The block
//               lights one digit at a time for CLK_DIV cycles, optionally
//               blanks all digits for GAP_CYC cycles between digits, and
//               hex-decodes each nibble. Per-digit blank and decimal-point
//               masks are applied. Frame contents come from a shadow copy
//               that is reloaded only at frame start, so updates never tear.
//
// Optional    : SEG_SCAN_LZS_EN
//               When defined, CTRL[12] (LZS) enables leading-zero
//               suppression on digits 3..1.
//
// Ports       : clk         system clock, rising edge
//               reset       asynchronous active-low reset
//               CtrlRead    bus read strobe
//               CtrlWrite   bus write strobe
//               Addr        register select (0 = VALUE, 1 = CTRL)
//               Write_data  bus write data
//               Read_data   bus read data (combinational)
//               sel         one-hot digit enable, active-high
//               seg         segments {dp, g..a}, active-high
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CtrlRead,
  input  logic        CtrlWrite,
  input  logic        Addr,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? ((CLK_DIV > 2) ? CLK_DIV : 2)
                                               : ((GAP_CYC > 2) ? GAP_CYC : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Live bus-visible registers
  logic [15:0] value;
  logic        en;
  logic [3:0]  blank;
  logic [3:0]  dp;

  // Frame shadow
  logic [15:0] sh_value, nxt_sh_value;
  logic [3:0]  sh_blank, nxt_sh_blank;
  logic [3:0]  sh_dp,    nxt_sh_dp;

  // Scan state
  logic [1:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt,   nxt_cnt;
  logic [1:0]       idx,   nxt_idx;
  logic             load_shadow;

  logic [3:0]  nxt_sel;
  logic [7:0]  nxt_seg;
  logic [3:0]  digit;
  logic [3:0]  lead_zero;
  logic        lzs_rd;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Bus registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      en    <= 1'b0;
      blank <= '0;
      dp    <= '0;
    end else if (CtrlWrite) begin
      if (!Addr) begin
        value <= Write_data[15:0];
      end else begin
        en    <= Write_data[0];
        blank <= Write_data[7:4];
        dp    <= Write_data[11:8];
      end
    end
  end

`ifdef SEG_SCAN_LZS_EN
  logic lzs, sh_lzs, nxt_sh_lzs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lzs    <= 1'b0;
      sh_lzs <= 1'b0;
    end else begin
      if (CtrlWrite && Addr) lzs <= Write_data[12];
      sh_lzs <= nxt_sh_lzs;
    end
  end

  assign nxt_sh_lzs = load_shadow ? lzs : sh_lzs;
  assign lzs_rd     = lzs;

  // A digit is suppressed when it and every digit above it are zero.
  // Digit0 always shows so that a zero value still displays "0".
  always_comb begin
    lead_zero = '0;
    if (nxt_sh_lzs) begin
      lead_zero[3] = (nxt_sh_value[15:12] == 4'h0);
      lead_zero[2] = lead_zero[3] && (nxt_sh_value[11:8] == 4'h0);
      lead_zero[1] = lead_zero[2] && (nxt_sh_value[7:4]  == 4'h0);
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{Write_data[31:13], Write_data[3:1]};
`else
  assign lead_zero = '0;
  assign lzs_rd    = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^{Write_data[31:12], Write_data[3:1]};
`endif

  // --------------------------------------------------------------------------
  // Bus read
  // --------------------------------------------------------------------------
  assign Read_data = !CtrlRead ? 32'b0
                   : (Addr ? {19'b0, lzs_rd, dp, blank, 3'b0, en}
                           : {16'b0, value});

  // --------------------------------------------------------------------------
  // Scan FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_idx     = idx;
    load_shadow = 1'b0;

    if (!en) begin
      nxt_state = ST_OFF;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          nxt_state   = ST_SHOW;
          nxt_cnt     = '0;
          nxt_idx     = '0;
          load_shadow = 1'b1;
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            nxt_cnt = '0;
            if (GAP_CYC == 0) begin
              nxt_idx     = idx + 2'd1;
              load_shadow = (idx == 2'd3);
            end else begin
              nxt_state = ST_GAP;
            end
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            nxt_cnt     = '0;
            nxt_state   = ST_SHOW;
            nxt_idx     = idx + 2'd1;
            load_shadow = (idx == 2'd3);
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = ST_OFF;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      endcase
    end

    // Shadow samples the live registers as they stood before this edge,
    // so a write landing on a wrap edge shows from the following frame.
    nxt_sh_value = load_shadow ? value : sh_value;
    nxt_sh_blank = load_shadow ? blank : sh_blank;
    nxt_sh_dp    = load_shadow ? dp    : sh_dp;
  end

  // --------------------------------------------------------------------------
  // Output decode from next-state values, so sel/seg change on the same
  // edge as the FSM transition.
  // --------------------------------------------------------------------------
  always_comb begin
    digit   = nxt_sh_value[{nxt_idx, 2'b00} +: 4];
    nxt_sel = '0;
    nxt_seg = '0;
    if (nxt_state == ST_SHOW) begin
      nxt_sel = 4'b0001 << nxt_idx;
      if (nxt_sh_blank[nxt_idx]) begin
        nxt_seg = 8'h00;
      end else if (lead_zero[nxt_idx]) begin
        nxt_seg = {nxt_sh_dp[nxt_idx], 7'h00};
      end else begin
        nxt_seg = {nxt_sh_dp[nxt_idx], hex_decode(digit)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_OFF;
      cnt      <= '0;
      idx      <= '0;
      sh_value <= '0;
      sh_blank <= '0;
      sh_dp    <= '0;
      sel      <= '0;
      seg      <= '0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      idx      <= nxt_idx;
      sh_value <= nxt_sh_value;
      sh_blank <= nxt_sh_blank;
      sh_dp    <= nxt_sh_dp;
      sel      <= nxt_sel;
      seg      <= nxt_seg;
    end
  end

endmodule
`default_nettype wire
